decode_stage_hz: RTL and testbench
==================================

Name: decode_stage_hz

Overview:
- Parametrised successor of the fixed 24-bit, 16-register decode stage.
- Splits a 32-bit instruction into its fields and generates control flags internally.
- Holds the register file, with write-back bypass so a same-cycle write is visible to a same-cycle read.
- Detects load-use hazards against the instruction in ID/EX, stalls fetch and inserts bubbles.
- Registers everything into a flushable, stallable ID/EX stage, and counts inserted bubbles for performance monitoring.
- Sits between the IF/ID buffer and the execute stage.

Parameters:
- DATA_W, 24, datapath and register width.
- REG_ADDR_W, 4, register index width; register count is 2**REG_ADDR_W. Legal range 2..4, because the instruction fields are 4 bits; upper field bits are ignored when REG_ADDR_W < 4.
- IMM_W, 18, immediate field width inst[IMM_W-1:0]. Must satisfy IMM_W <= 18 and IMM_W <= DATA_W.
- CNT_W, 16, bubble-counter width.

Ports:
- clk, in, 1: clock, all state on rising edge.
- rst, in, 1: asynchronous active-low reset.
- en, in, 1: downstream ready. 0 = ID/EX holds.
- flush, in, 1: branch taken. Next edge turns ID/EX into a bubble.
- inst, in, 32: instruction from IF/ID.
- inst_valid, in, 1: inst is real (not a bubble).
- pc, in, DATA_W: PC of inst.
- wb_we, in, 1: write-back enable.
- wb_rd, in, REG_ADDR_W: write-back register.
- wb_wd, in, DATA_W: write-back data.
- stall, out, 1: combinational; fetch and IF/ID must hold.
- ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch, ex_imm_src, out, 1 each: registered control.
- ex_op_type, out, 2; ex_op_code, out, 4; ex_alu_control, out, 4.
- ex_pc, ex_rd1, ex_rd2, ex_rd3, ex_imm, out, DATA_W each.
- ex_ra, ex_rb, ex_rc, out, REG_ADDR_W each.
- bubble_count, out, CNT_W: saturating count of hazard bubbles.

Behaviour:
- Instruction fields:
  - op_type = inst[31:30], op_code = inst[29:26].
  - rc = inst[25:22], ra = inst[21:18], rb = inst[17:14].
  - imm = inst[IMM_W-1:0], sign-extended to DATA_W.
- Control decode:
  - op_type 00 (reg ALU): reg_write=1, imm_src=0, alu_control=op_code.
  - op_type 11 (imm ALU): reg_write=1, imm_src=1, alu_control=op_code.
  - op_type 01 (memory): op_code 0000 = load (reg_write, mem_to_reg, imm_src); op_code 0001 = store (mem_write, imm_src); any other op_code = no flags set. alu_control=0000.
  - op_type 10 (branch): branch=1, imm_src=1, alu_control=0000.
  - If inst_valid=0, all flags are 0.
- Register file:
  - 2**REG_ADDR_W x DATA_W; all entries 0 on reset.
  - Written at the edge when wb_we=1. R0 is an ordinary register.
  - Reads are combinational: rd1 = R[ra], rd2 = R[rb], rd3 = R[rc].
  - Bypass: if wb_we=1 and wb_rd equals a read index, that read returns wb_wd in the same cycle.
- Hazard:
  - hazard = inst_valid & ex_valid & ex_mem_to_reg & src_match.
  - src_match is true when ex_rc equals any register the instruction reads:
    - ra, always;
    - rb, only when op_type=00;
    - rc, only when the instruction is a store.
  - stall = hazard & en.
- ID/EX update on each edge, first matching rule wins:
  - flush=1: valid and all control go to 0; data fields go to 0.
  - en=0: hold everything.
  - hazard=1: bubble (same as flush); bubble_count increments, saturating at all-ones.
  - otherwise: capture decoded values; ex_valid = inst_valid.
- Latency: one cycle from inst to ex_* outputs. A load-use pair costs exactly one bubble: the load moves to MEM, so the hazard clears on the next cycle.
- Flush and hazard in the same cycle: bubble inserted, bubble_count does NOT increment, stall still asserted that cycle.
- Reset: every ex_* output, bubble_count and all registers go to 0 immediately (asynchronous). stall is 0 because ex_valid=0. Mid-operation reset discards in-flight state.

Decomposition:
- Package decode_pkg holds:
  - op_type constants: OPT_REG=2'b00, OPT_MEM=2'b01, OPT_BR=2'b10, OPT_IMM=2'b11;
  - OPC_LOAD=4'b0000, OPC_STORE=4'b0001;
  - a packed struct ctrl_t with valid, reg_write, mem_to_reg, mem_write, branch, imm_src, alu_control.
- One sub-module: reg_file_bypass (parametrised register bank with write-first bypass).
- Control decode and hazard logic stay inline.

Test Plan:
- Reset mid-run with ex_valid=1 → all ex_* outputs and bubble_count read 0 before the next edge; stall=0.
- Write R3=24'h00ABCD; same cycle decode an op_type 00 instruction with ra=3 → ex_rd1=24'h00ABCD one edge later (bypass).
- Load with rc=5, next instruction op_type 00 with rb=5 → stall=1 for one cycle, one bubble (ex_valid=0), then the dependent instruction captured; bubble_count=1.
- Same load followed by op_type 11 with rb=5 and ra=2 → no stall (rb unused).
- flush=1 together with a hazard → ex_valid=0, bubble_count unchanged; en=0 with a hazard → ID/EX holds, stall=0.
- imm=18'h20000 with DATA_W=24 → ex_imm=24'hFE0000; with DATA_W=32, REG_ADDR_W=3 → ex_imm=32'hFFFE0000 and only R0..R7 are addressed.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings and the control bundle for the decode stage.
// decode_ctrl turns op_type/op_code into the control flags carried into ID/EX.
package decode_pkg;

    localparam logic [1:0] OPT_REG = 2'b00;
    localparam logic [1:0] OPT_MEM = 2'b01;
    localparam logic [1:0] OPT_BR  = 2'b10;
    localparam logic [1:0] OPT_IMM = 2'b11;

    localparam logic [3:0] OPC_LOAD  = 4'b0000;
    localparam logic [3:0] OPC_STORE = 4'b0001;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       imm_src;
        logic [3:0] alu_control;
    } ctrl_t;

    // A bubble (valid=0) carries no flags at all, including alu_control.
    function automatic ctrl_t decode_ctrl(input logic [1:0] op_type,
                                          input logic [3:0] op_code,
                                          input logic       valid);
        ctrl_t c;
        c = '0;
        if (valid) begin
            c.valid = 1'b1;
            case (op_type)
                OPT_REG: begin
                    c.reg_write   = 1'b1;
                    c.alu_control = op_code;
                end
                OPT_IMM: begin
                    c.reg_write   = 1'b1;
                    c.imm_src     = 1'b1;
                    c.alu_control = op_code;
                end
                OPT_MEM: begin
                    if (op_code == OPC_LOAD) begin
                        c.reg_write  = 1'b1;
                        c.mem_to_reg = 1'b1;
                        c.imm_src    = 1'b1;
                    end else if (op_code == OPC_STORE) begin
                        c.mem_write = 1'b1;
                        c.imm_src   = 1'b1;
                    end
                end
                default: begin
                    c.branch  = 1'b1;
                    c.imm_src = 1'b1;
                end
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Register bank with three combinational read ports and write-first bypass:
// a write in progress is visible to reads in the same cycle.
module reg_file_bypass #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[wa] = wd;
    end

    // Reading the next-state image is exactly the write-first bypass.
    assign rd1 = mem_d[ra1];
    assign rd2 = mem_d[ra2];
    assign rd3 = mem_d[ra3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_q <= '{default: '0};
        else      mem_q <= mem_d;
    end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage: field split, control decode, register read with bypass,
// load-use hazard detection and a flushable/stallable ID/EX register.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int REG_ADDR_W = 4,
    parameter int IMM_W      = 18,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic [31:0]           inst,
    input  logic                  inst_valid,
    input  logic [DATA_W-1:0]     pc,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_wd,
    output logic                  stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_imm_src,
    output logic [1:0]            ex_op_type,
    output logic [3:0]            ex_op_code,
    output logic [3:0]            ex_alu_control,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_rd3,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_ra,
    output logic [REG_ADDR_W-1:0] ex_rb,
    output logic [REG_ADDR_W-1:0] ex_rc,
    output logic [CNT_W-1:0]      bubble_count
);

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [1:0]            op_type;
        logic [3:0]            op_code;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     rd3;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] ra;
        logic [REG_ADDR_W-1:0] rb;
        logic [REG_ADDR_W-1:0] rc;
    } idex_t;

    idex_t            idex_q, idex_d, idex_dec;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic [1:0]            op_type;
    logic [3:0]            op_code;
    logic [REG_ADDR_W-1:0] ra, rb, rc;
    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     rd1, rd2, rd3;
    logic                  is_store, src_match, hazard;

    // Upper register-field bits are intentionally dropped for narrow banks.
    logic unused_inst;
    assign unused_inst = ^inst;

    assign op_type = inst[31:30];
    assign op_code = inst[29:26];
    assign rc      = inst[22 +: REG_ADDR_W];
    assign ra      = inst[18 +: REG_ADDR_W];
    assign rb      = inst[14 +: REG_ADDR_W];
    assign imm_ext = DATA_W'($signed(inst[IMM_W-1:0]));

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_wd),
        .ra1 (ra),
        .ra2 (rb),
        .ra3 (rc),
        .rd1 (rd1),
        .rd2 (rd2),
        .rd3 (rd3)
    );

    // rb is a source only for reg-reg ALU ops; rc only for stores (store data).
    assign is_store  = (op_type == OPT_MEM) && (op_code == OPC_STORE);
    assign src_match = (idex_q.rc == ra)
                     | ((op_type == OPT_REG) && (idex_q.rc == rb))
                     | (is_store && (idex_q.rc == rc));
    assign hazard    = inst_valid & idex_q.ctrl.valid & idex_q.ctrl.mem_to_reg & src_match;
    assign stall     = hazard & en;

    always_comb begin
        idex_dec         = '0;
        idex_dec.ctrl    = decode_ctrl(op_type, op_code, inst_valid);
        idex_dec.op_type = op_type;
        idex_dec.op_code = op_code;
        idex_dec.pc      = pc;
        idex_dec.rd1     = rd1;
        idex_dec.rd2     = rd2;
        idex_dec.rd3     = rd3;
        idex_dec.imm     = imm_ext;
        idex_dec.ra      = ra;
        idex_dec.rb      = rb;
        idex_dec.rc      = rc;
    end

    // Flush outranks hold and hazard; only a hazard-only bubble is counted.
    always_comb begin
        idex_d   = idex_q;
        bubble_d = bubble_q;
        if (flush) begin
            idex_d = '0;
        end else if (!en) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d = '0;
            if (bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
        end else begin
            idex_d = idex_dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q   <= '0;
            bubble_q <= '0;
        end else begin
            idex_q   <= idex_d;
            bubble_q <= bubble_d;
        end
    end

    assign ex_valid       = idex_q.ctrl.valid;
    assign ex_reg_write   = idex_q.ctrl.reg_write;
    assign ex_mem_to_reg  = idex_q.ctrl.mem_to_reg;
    assign ex_mem_write   = idex_q.ctrl.mem_write;
    assign ex_branch      = idex_q.ctrl.branch;
    assign ex_imm_src     = idex_q.ctrl.imm_src;
    assign ex_alu_control = idex_q.ctrl.alu_control;
    assign ex_op_type     = idex_q.op_type;
    assign ex_op_code     = idex_q.op_code;
    assign ex_pc          = idex_q.pc;
    assign ex_rd1         = idex_q.rd1;
    assign ex_rd2         = idex_q.rd2;
    assign ex_rd3         = idex_q.rd3;
    assign ex_imm         = idex_q.imm;
    assign ex_ra          = idex_q.ra;
    assign ex_rb          = idex_q.rb;
    assign ex_rc          = idex_q.rc;
    assign bubble_count   = bubble_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: a default-width instance plus a 32-bit,
// 8-register, 2-bit-counter instance sharing the instruction stream.
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1, flush = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic [23:0] pc = '0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic [23:0] wb_wd = '0;

  logic        stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch, ex_imm_src;
  logic [1:0]  ex_op_type;
  logic [3:0]  ex_op_code, ex_alu_control;
  logic [23:0] ex_pc, ex_rd1, ex_rd2, ex_rd3, ex_imm;
  logic [3:0]  ex_ra, ex_rb, ex_rc;
  logic [15:0] bubble_count;

  logic [31:0] pc_b = '0;
  logic        wb_we_b = 1'b0;
  logic [2:0]  wb_rd_b = '0;
  logic [31:0] wb_wd_b = '0;
  logic        stall_b, ex_valid_b, ex_reg_write_b, ex_mem_to_reg_b, ex_mem_write_b, ex_branch_b, ex_imm_src_b;
  logic [1:0]  ex_op_type_b;
  logic [3:0]  ex_op_code_b, ex_alu_control_b;
  logic [31:0] ex_pc_b, ex_rd1_b, ex_rd2_b, ex_rd3_b, ex_imm_b;
  logic [2:0]  ex_ra_b, ex_rb_b, ex_rc_b;
  logic [1:0]  bubble_count_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage_hz dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_imm_src(ex_imm_src),
    .ex_op_type(ex_op_type), .ex_op_code(ex_op_code), .ex_alu_control(ex_alu_control),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rd3(ex_rd3), .ex_imm(ex_imm),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rc(ex_rc), .bubble_count(bubble_count)
  );

  decode_stage_hz #(.DATA_W(32), .REG_ADDR_W(3), .IMM_W(18), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .inst(inst), .inst_valid(inst_valid),
    .pc(pc_b), .wb_we(wb_we_b), .wb_rd(wb_rd_b), .wb_wd(wb_wd_b), .stall(stall_b),
    .ex_valid(ex_valid_b), .ex_reg_write(ex_reg_write_b), .ex_mem_to_reg(ex_mem_to_reg_b),
    .ex_mem_write(ex_mem_write_b), .ex_branch(ex_branch_b), .ex_imm_src(ex_imm_src_b),
    .ex_op_type(ex_op_type_b), .ex_op_code(ex_op_code_b), .ex_alu_control(ex_alu_control_b),
    .ex_pc(ex_pc_b), .ex_rd1(ex_rd1_b), .ex_rd2(ex_rd2_b), .ex_rd3(ex_rd3_b), .ex_imm(ex_imm_b),
    .ex_ra(ex_ra_b), .ex_rb(ex_rb_b), .ex_rc(ex_rc_b), .bubble_count(bubble_count_b)
  );

  function automatic logic [31:0] mk(input logic [1:0] ot, input logic [3:0] oc,
                                     input logic [3:0] rc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [13:0] lo);
    return {ot, oc, rc, ra, rb, lo};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
    n_checks++; if (bubble_count !== 16'd0) begin n_errors++; $display("FAIL reset_bubble got %0d exp 0", bubble_count); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    wb_we = 1'b1; wb_rd = 4'd3; wb_wd = 24'h00ABCD;
    inst = mk(2'b00, 4'b0010, 4'd1, 4'd3, 4'd4, 14'h0); inst_valid = 1'b1; pc = 24'h000100;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL bypass_stall got %b exp 0", stall); end
    step();
    wb_we = 1'b0;
    n_checks++; if (ex_rd1 !== 24'h00ABCD) begin n_errors++; $display("FAIL bypass_rd1 got %h exp 00abcd", ex_rd1); end
    n_checks++; if (ex_rd2 !== 24'h0) begin n_errors++; $display("FAIL bypass_rd2 got %h exp 0", ex_rd2); end
    n_checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_imm_src !== 1'b0) begin
      n_errors++; $display("FAIL bypass_ctrl got v%b rw%b is%b exp v1 rw1 is0", ex_valid, ex_reg_write, ex_imm_src); end
    n_checks++; if (ex_alu_control !== 4'd2) begin n_errors++; $display("FAIL bypass_alu got %h exp 2", ex_alu_control); end
    n_checks++; if (ex_pc !== 24'h000100 || ex_ra !== 4'd3) begin n_errors++; $display("FAIL bypass_pc_ra got %h/%0d exp 000100/3", ex_pc, ex_ra); end
  endtask

  task automatic test_load_use();
    inst = mk(2'b01, 4'b0000, 4'd5, 4'd3, 4'd0, 14'h0010); pc = 24'h000104;
    step();
    n_checks++; if (ex_mem_to_reg !== 1'b1 || ex_reg_write !== 1'b1 || ex_imm_src !== 1'b1 || ex_mem_write !== 1'b0) begin
      n_errors++; $display("FAIL load_ctrl got m2r%b rw%b is%b mw%b exp 1 1 1 0", ex_mem_to_reg, ex_reg_write, ex_imm_src, ex_mem_write); end
    n_checks++; if (ex_imm !== 24'h000010 || ex_rc !== 4'd5) begin n_errors++; $display("FAIL load_imm_rc got %h/%0d exp 000010/5", ex_imm, ex_rc); end
    n_checks++; if (ex_rd1 !== 24'h00ABCD) begin n_errors++; $display("FAIL load_rd1 got %h exp 00abcd", ex_rd1); end
    inst = mk(2'b00, 4'b0001, 4'd6, 4'd1, 4'd5, 14'h0); pc = 24'h000108;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b0 || bubble_count !== 16'd1) begin n_errors++; $display("FAIL lu_bubble got v%b cnt%0d exp v0 cnt1", ex_valid, bubble_count); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_stall_clear got %b exp 0", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rb !== 4'd5 || ex_rc !== 4'd6 || ex_alu_control !== 4'd1) begin
      n_errors++; $display("FAIL lu_capture got v%b rb%0d rc%0d alu%0d exp v1 rb5 rc6 alu1", ex_valid, ex_rb, ex_rc, ex_alu_control); end
    n_checks++; if (ex_pc !== 24'h000108 || bubble_count !== 16'd1) begin n_errors++; $display("FAIL lu_pc_cnt got %h/%0d exp 000108/1", ex_pc, bubble_count); end
  endtask

  task automatic test_no_stall_and_store();
    inst = mk(2'b01, 4'b0000, 4'd5, 4'd3, 4'd0, 14'h0010); pc = 24'h00010C;
    step();
    inst = mk(2'b11, 4'b0011, 4'd7, 4'd2, 4'd5, 14'h0); pc = 24'h000110;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL imm_rb_stall got %b exp 0", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_imm_src !== 1'b1 || ex_alu_control !== 4'd3 || bubble_count !== 16'd1) begin
      n_errors++; $display("FAIL imm_capture got v%b is%b alu%0d cnt%0d exp v1 is1 alu3 cnt1", ex_valid, ex_imm_src, ex_alu_control, bubble_count); end
    n_checks++; if (ex_imm !== 24'h014000) begin n_errors++; $display("FAIL imm_pos got %h exp 014000", ex_imm); end
    inst = mk(2'b01, 4'b0000, 4'd5, 4'd3, 4'd0, 14'h0);
    step();
    inst = mk(2'b01, 4'b0001, 4'd5, 4'd2, 4'd0, 14'h0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL store_rc_stall got %b exp 1", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b0 || bubble_count !== 16'd2) begin n_errors++; $display("FAIL store_bubble got v%b cnt%0d exp v0 cnt2", ex_valid, bubble_count); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 || ex_imm_src !== 1'b1) begin
      n_errors++; $display("FAIL store_ctrl got v%b mw%b rw%b is%b exp 1 1 0 1", ex_valid, ex_mem_write, ex_reg_write, ex_imm_src); end
  endtask

  task automatic test_flush_and_hold();
    inst = mk(2'b01, 4'b0000, 4'd5, 4'd3, 4'd0, 14'h0);
    step();
    inst = mk(2'b00, 4'b0000, 4'd6, 4'd5, 4'd1, 14'h0); flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL flush_hz_stall got %b exp 1", stall); end
    step();
    flush = 1'b0;
    n_checks++; if (ex_valid !== 1'b0 || bubble_count !== 16'd2) begin n_errors++; $display("FAIL flush_hz got v%b cnt%0d exp v0 cnt2", ex_valid, bubble_count); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_ra !== 4'd5) begin n_errors++; $display("FAIL flush_after got v%b ra%0d exp v1 ra5", ex_valid, ex_ra); end
    inst = mk(2'b01, 4'b0000, 4'd5, 4'd3, 4'd0, 14'h0);
    step();
    inst = mk(2'b00, 4'b0000, 4'd6, 4'd5, 4'd1, 14'h0); en = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL hold_stall got %b exp 0", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_mem_to_reg !== 1'b1 || ex_rc !== 4'd5 || bubble_count !== 16'd2) begin
      n_errors++; $display("FAIL hold_state got v%b m2r%b rc%0d cnt%0d exp v1 m2r1 rc5 cnt2", ex_valid, ex_mem_to_reg, ex_rc, bubble_count); end
    en = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL release_stall got %b exp 1", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b0 || bubble_count !== 16'd3) begin n_errors++; $display("FAIL release_bubble got v%b cnt%0d exp v0 cnt3", ex_valid, bubble_count); end
    step();
    n_checks++; if (ex_valid !== 1'b1) begin n_errors++; $display("FAIL release_capture got %b exp 1", ex_valid); end
  endtask

  task automatic test_decode_misc();
    inst = mk(2'b01, 4'b0101, 4'd1, 4'd2, 4'd3, 14'h0);
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_to_reg !== 1'b0 || ex_mem_write !== 1'b0 || ex_imm_src !== 1'b0) begin
      n_errors++; $display("FAIL mem_other got v%b rw%b m2r%b mw%b is%b exp 1 0 0 0 0", ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_imm_src); end
    inst = mk(2'b10, 4'b0110, 4'd1, 4'd2, 4'd3, 14'h0);
    step();
    n_checks++; if (ex_branch !== 1'b1 || ex_imm_src !== 1'b1 || ex_alu_control !== 4'd0 || ex_reg_write !== 1'b0) begin
      n_errors++; $display("FAIL branch_ctrl got br%b is%b alu%0d rw%b exp 1 1 0 0", ex_branch, ex_imm_src, ex_alu_control, ex_reg_write); end
    n_checks++; if (ex_op_type !== 2'b10 || ex_op_code !== 4'b0110) begin n_errors++; $display("FAIL branch_fields got %b/%b exp 10/0110", ex_op_type, ex_op_code); end
    inst = mk(2'b00, 4'b0011, 4'd1, 4'd2, 4'd3, 14'h0); inst_valid = 1'b0;
    step();
    inst_valid = 1'b1;
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_imm_src !== 1'b0) begin
      n_errors++; $display("FAIL invalid_ctrl got v%b rw%b is%b exp 0 0 0", ex_valid, ex_reg_write, ex_imm_src); end
  endtask

  task automatic test_params_imm();
    inst = mk(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 14'h0);
    wb_we_b = 1'b1; wb_rd_b = 3'd2; wb_wd_b = 32'h12345678;
    step();
    wb_we_b = 1'b0;
    inst = mk(2'b11, 4'b0000, 4'd0, 4'hA, 4'h8, 14'h0);
    step();
    n_checks++; if (ex_imm !== 24'hFE0000) begin n_errors++; $display("FAIL imm_sext24 got %h exp fe0000", ex_imm); end
    n_checks++; if (ex_imm_b !== 32'hFFFE0000) begin n_errors++; $display("FAIL imm_sext32 got %h exp fffe0000", ex_imm_b); end
    n_checks++; if (ex_ra_b !== 3'd2 || ex_rb_b !== 3'd0 || ex_rd1_b !== 32'h12345678) begin
      n_errors++; $display("FAIL narrow_addr got ra%0d rb%0d rd1 %h exp ra2 rb0 rd1 12345678", ex_ra_b, ex_rb_b, ex_rd1_b); end
    n_checks++; if (ex_ra !== 4'hA || ex_rd1 !== 24'h0) begin n_errors++; $display("FAIL wide_addr got ra%0d rd1 %h exp ra10 rd1 0", ex_ra, ex_rd1); end
    n_checks++; if (bubble_count_b !== 2'd3) begin n_errors++; $display("FAIL narrow_cnt got %0d exp 3", bubble_count_b); end
  endtask

  task automatic test_saturation();
    inst = mk(2'b01, 4'b0000, 4'd5, 4'd3, 4'd0, 14'h0);
    step();
    inst = mk(2'b00, 4'b0000, 4'd6, 4'd5, 4'd0, 14'h0);
    step();
    n_checks++; if (bubble_count !== 16'd4 || bubble_count_b !== 2'd3) begin
      n_errors++; $display("FAIL saturate got %0d/%0d exp 4/3", bubble_count, bubble_count_b); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin n_errors++; $display("FAIL sat_capture got v%b rw%b exp 1 1", ex_valid, ex_reg_write); end
  endtask

  task automatic test_mid_reset();
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_control !== 4'd0 || ex_ra !== 4'd0) begin
      n_errors++; $display("FAIL mid_reset_ctrl got v%b rw%b alu%0d ra%0d exp all 0", ex_valid, ex_reg_write, ex_alu_control, ex_ra); end
    n_checks++; if (ex_pc !== 24'h0 || ex_rd1 !== 24'h0 || ex_rc !== 4'd0) begin n_errors++; $display("FAIL mid_reset_data got pc%h rd1 %h rc%0d exp 0", ex_pc, ex_rd1, ex_rc); end
    n_checks++; if (bubble_count !== 16'd0 || bubble_count_b !== 2'd0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_cnt got %0d/%0d stall%b exp 0/0 stall0", bubble_count, bubble_count_b, stall); end
    #2;
    rst = 1'b1;
    inst = mk(2'b00, 4'b0000, 4'd0, 4'd3, 4'd0, 14'h0);
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rd1 !== 24'h0) begin n_errors++; $display("FAIL reset_regfile got v%b rd1 %h exp v1 rd1 0", ex_valid, ex_rd1); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_no_stall_and_store();
    test_flush_and_hold();
    test_decode_misc();
    test_params_imm();
    test_saturation();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
